// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, register index type and the
// ALU control encodings consumed downstream of the register file.
package core_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [XLEN-1:0]       xlen_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011
  } alu_ctrl_t;

  // Reference behaviour of the downstream ALU for the encodings above.
  function automatic xlen_t alu_eval(input alu_ctrl_t op, input xlen_t a, input xlen_t b);
    xlen_t res;
    res = '0;
    case (op)
      ALU_ADD: res = a + b;
      ALU_SUB: res = a - b;
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/reg_file.sv
// Integer register file: NUM_REGS x XLEN, two combinational read ports,
// one synchronous write port, x0 hardwired to zero, optional write bypass.
module reg_file #(
  parameter int XLEN     = core_pkg::XLEN,
  parameter int NUM_REGS = core_pkg::NUM_REGS,
  parameter bit BYPASS   = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  core_pkg::reg_addr_t rs1_addr,
  input  core_pkg::reg_addr_t rs2_addr,
  input  core_pkg::reg_addr_t rd_addr,
  input  logic [XLEN-1:0]    rd_data,
  input  logic               reg_write,
  output logic [XLEN-1:0]    rs1_data,
  output logic [XLEN-1:0]    rs2_data
);
  import core_pkg::*;

  // Entry 0 has no storage; indices start at 1.
  logic [XLEN-1:0] regs [1:NUM_REGS-1];

  logic            rd_in_range;
  logic            fwd_en;
  logic [XLEN-1:0] rs1_stored;
  logic [XLEN-1:0] rs2_stored;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          regs[gi] <= '0;
        end else if (reg_write && (rd_addr == REG_ADDR_W'(gi))) begin
          regs[gi] <= rd_data;
        end
      end
    end
  endgenerate

  // Address 0 and indices at or beyond NUM_REGS fall through to zero.
  function automatic logic [XLEN-1:0] lookup(input reg_addr_t addr);
    logic [XLEN-1:0] val;
    val = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (addr == REG_ADDR_W'(i)) val = regs[i];
    end
    return val;
  endfunction

  always_comb begin
    rd_in_range = (int'(rd_addr) < NUM_REGS);
    fwd_en      = BYPASS && reg_write && (rd_addr != '0) && rd_in_range;
  end

  always_comb begin
    rs1_stored = lookup(rs1_addr);
    rs2_stored = lookup(rs2_addr);
  end

  // Reset also masks the bypass path so every read is zero while rst_n is low.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rst_n) begin
      rs1_data = (fwd_en && (rd_addr == rs1_addr)) ? rd_data : rs1_stored;
      rs2_data = (fwd_en && (rd_addr == rs2_addr)) ? rd_data : rs2_stored;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: BYPASS=0, BYPASS=1 and a 16-entry
// instance share stimulus and are checked against an array model.
module tb_reg_file;
  import core_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [63:0] rd_data;
  logic        reg_write;
  logic [63:0] rs1_nb, rs2_nb, rs1_by, rs2_by, rs1_sm, rs2_sm;
  logic [63:0] r1 [3];
  logic [63:0] r2 [3];

  logic [63:0] model [32];
  logic [63:0] small_model [32];
  int checks = 0;
  int errors = 0;

  reg_file #(.XLEN(64), .NUM_REGS(32), .BYPASS(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd_addr(rd_addr), .rd_data(rd_data), .reg_write(reg_write),
    .rs1_data(rs1_nb), .rs2_data(rs2_nb));

  reg_file #(.XLEN(64), .NUM_REGS(32), .BYPASS(1'b1)) dut_byp (
    .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd_addr(rd_addr), .rd_data(rd_data), .reg_write(reg_write),
    .rs1_data(rs1_by), .rs2_data(rs2_by));

  reg_file #(.XLEN(64), .NUM_REGS(16), .BYPASS(1'b0)) dut_small (
    .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd_addr(rd_addr), .rd_data(rd_data), .reg_write(reg_write),
    .rs1_data(rs1_sm), .rs2_data(rs2_sm));

  assign r1[0] = rs1_nb;
  assign r1[1] = rs1_by;
  assign r1[2] = rs1_sm;
  assign r2[0] = rs2_nb;
  assign r2[1] = rs2_by;
  assign r2[2] = rs2_sm;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural view: sel 0 = no bypass, 1 = bypass, 2 = 16-entry file.
  function automatic logic [63:0] exp_rd(input int sel, input logic [4:0] a);
    if (!rst_n) return 64'h0;
    if (a == 5'd0) return 64'h0;
    if (sel == 2 && a >= 5'd16) return 64'h0;
    if (sel == 1 && reg_write && rd_addr == a) return rd_data;
    return (sel == 2) ? small_model[a] : model[a];
  endfunction

  task automatic clear_models();
    for (int i = 0; i < 32; i++) begin
      model[i] = 64'h0;
      small_model[i] = 64'h0;
    end
  endtask

  // Advance one rising edge, committing the write the spec says is taken.
  task automatic step();
    @(posedge clk);
    if (rst_n && reg_write && rd_addr != 5'd0) begin
      model[rd_addr] = rd_data;
      if (rd_addr < 5'd16) small_model[rd_addr] = rd_data;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; reg_write = 1'b0; rd_addr = 5'd0; rd_data = 64'h0;
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    clear_models();
    step(); step();
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
      #1;
      for (int d = 0; d < 3; d++) begin
        checks += 2;
        if (r1[d] !== 64'h0 || r2[d] !== 64'h0) begin
          errors++;
          $display("FAIL reset_read dut%0d addr=%0d: rs1=%h rs2=%h required 0", d, i, r1[d], r2[d]);
        end
      end
    end
  endtask

  task automatic test_write_read();
    reg_write = 1'b1; rd_addr = 5'd5; rd_data = 64'd10; step();
    rd_addr = 5'd6; rd_data = 64'd5; step();
    reg_write = 1'b0; rs1_addr = 5'd5; rs2_addr = 5'd6;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (r1[d] !== 64'd10 || r2[d] !== 64'd5) begin
        errors++;
        $display("FAIL write_read dut%0d: rs1=%0d rs2=%0d required 10/5", d, r1[d], r2[d]);
      end
    end
    checks++;
    if (alu_eval(ALU_ADD, rs1_nb, rs2_nb) !== 64'd15) begin
      errors++;
      $display("FAIL alu_add: got %0d required 15", alu_eval(ALU_ADD, rs1_nb, rs2_nb));
    end
  endtask

  task automatic test_x0();
    reg_write = 1'b1; rd_addr = 5'd0; rd_data = 64'hDEADBEEF;
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (r1[d] !== 64'h0 || r2[d] !== 64'h0) begin
        errors++;
        $display("FAIL x0_same_cycle dut%0d: rs1=%h rs2=%h required 0", d, r1[d], r2[d]);
      end
    end
    step();
    reg_write = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (r1[d] !== 64'h0) begin
        errors++;
        $display("FAIL x0_after_write dut%0d: rs1=%h required 0", d, r1[d]);
      end
    end
  endtask

  task automatic test_hazard();
    reg_write = 1'b1; rd_addr = 5'd7; rd_data = 64'd20; step();
    rd_data = 64'hF0F0F0F0F0F0F0F0; rs1_addr = 5'd7; rs2_addr = 5'd7;
    #1;
    checks += 2;
    if (rs1_nb !== 64'd20 || rs2_nb !== 64'd20) begin
      errors++;
      $display("FAIL hazard_nobypass_pre: rs1=%h rs2=%h required %h", rs1_nb, rs2_nb, 64'd20);
    end
    if (rs1_by !== 64'hF0F0F0F0F0F0F0F0 || rs2_by !== 64'hF0F0F0F0F0F0F0F0) begin
      errors++;
      $display("FAIL hazard_bypass_pre: rs1=%h rs2=%h required f0f0f0f0f0f0f0f0", rs1_by, rs2_by);
    end
    step();
    reg_write = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (r1[d] !== 64'hF0F0F0F0F0F0F0F0 || r2[d] !== 64'hF0F0F0F0F0F0F0F0) begin
        errors++;
        $display("FAIL hazard_post dut%0d: rs1=%h rs2=%h required f0f0f0f0f0f0f0f0", d, r1[d], r2[d]);
      end
    end
  endtask

  task automatic test_async_reset();
    reg_write = 1'b1; rd_addr = 5'd9; rd_data = 64'hFFFFFFFFFFFFFFFF; step();
    rs1_addr = 5'd9; rd_data = 64'h0123456789ABCDEF;
    #2;
    checks++;
    if (rs1_nb !== 64'hFFFFFFFFFFFFFFFF) begin
      errors++;
      $display("FAIL async_pre: rs1=%h required ffffffffffffffff", rs1_nb);
    end
    rst_n = 1'b0;
    clear_models();
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (r1[d] !== 64'h0) begin
        errors++;
        $display("FAIL async_drop dut%0d: rs1=%h required 0", d, r1[d]);
      end
    end
    step();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (r1[d] !== 64'h0) begin
        errors++;
        $display("FAIL async_hold dut%0d: rs1=%h required 0", d, r1[d]);
      end
    end
    reg_write = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
    checks++;
    if (rs1_nb !== 64'h0 || rs1_by !== 64'h0) begin
      errors++;
      $display("FAIL async_write_lost: rs1=%h/%h required 0", rs1_nb, rs1_by);
    end
  endtask

  task automatic test_write_gating();
    reg_write = 1'b0; rd_addr = 5'd3; rd_data = 64'd99; rs1_addr = 5'd3; rs2_addr = 5'd3;
    repeat (3) step();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (r1[d] !== 64'h0 || r2[d] !== 64'h0) begin
        errors++;
        $display("FAIL write_gating dut%0d: rs1=%h rs2=%h required 0", d, r1[d], r2[d]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reg_write = ($urandom_range(0, 3) != 0);
      rd_addr   = 5'($urandom_range(0, 31));
      rd_data   = {$urandom, $urandom};
      rs1_addr  = ($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom_range(0, 31));
      rs2_addr  = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 99) == 0) begin
        #2;
        rst_n = 1'b0;
        clear_models();
      end
      #1;
      for (int d = 0; d < 3; d++) begin
        checks += 2;
        if (r1[d] !== exp_rd(d, rs1_addr)) begin
          errors++;
          $display("FAIL random_rs1 dut%0d iter=%0d addr=%0d: got %h required %h", d, n, rs1_addr, r1[d], exp_rd(d, rs1_addr));
        end
        if (r2[d] !== exp_rd(d, rs2_addr)) begin
          errors++;
          $display("FAIL random_rs2 dut%0d iter=%0d addr=%0d: got %h required %h", d, n, rs2_addr, r2[d], exp_rd(d, rs2_addr));
        end
      end
      step();
      rst_n = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_x0();
    test_hazard();
    test_async_reset();
    test_write_gating();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
